// File: rtl/bp_pkg.sv
// Shared types and constants for the gshare PHT sequencing controller.
// Default widths here size the update-queue entry and must match the controller parameters.
package bp_pkg;

    localparam int BP_PHT_IDX_W = 10;
    localparam int BP_GHR_SIZE  = 10;

    localparam logic [1:0] CTR_WNT = 2'b01;

    typedef enum logic [1:0] {
        INIT = 2'b00,
        IDLE = 2'b01,
        WR   = 2'b10
    } bp_state_e;

    typedef struct packed {
        logic [BP_PHT_IDX_W-1:0] pc_idx;
        logic [BP_GHR_SIZE-1:0]  ghr;
        logic                    taken;
    } uq_entry_t;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous FIFO buffering resolved-branch updates until the PHT port is free.
module bp_update_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_s, pop_s;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == {CNT_W{1'b0}});
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pushes into a full queue are dropped.
    always_comb begin
        push_s   = push && !full;
        pop_s    = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; occupancy tracks validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/bp_pht_ctrl.sv
// Gshare PHT port sequencer: init sweep, lookup/update arbitration, speculative GHR.
// Lookup reads win the port in IDLE; updates run as read-then-write in the gaps.
module bp_pht_ctrl import bp_pkg::*; #(
    parameter int GHR_SIZE  = BP_GHR_SIZE,
    parameter int PHT_IDX_W = BP_PHT_IDX_W,
    parameter int UQ_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lookup_valid,
    input  logic [31:0]          lookup_pc,
    output logic                 lookup_ready,
    output logic                 pred_valid,
    output logic                 pred_taken,
    output logic [GHR_SIZE-1:0]  pred_ghr,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_taken,
    input  logic [GHR_SIZE-1:0]  upd_ghr,
    input  logic                 upd_mispredict,
    output logic                 upd_ready,
    output logic                 pht_en,
    output logic                 pht_we,
    output logic [PHT_IDX_W-1:0] pht_idx,
    output logic [1:0]           pht_wdata,
    input  logic [1:0]           pht_rdata
);

    localparam logic [PHT_IDX_W-1:0] IDX_LAST = {PHT_IDX_W{1'b1}};

    bp_state_e            state_q, state_d;
    logic [PHT_IDX_W-1:0] init_idx_q, init_idx_d;
    logic [GHR_SIZE-1:0]  ghr_q, ghr_d, pred_ghr_q, pred_ghr_d;
    logic                 pred_valid_q, pred_valid_d;

    logic                 lookup_ready_s, upd_ready_s, lookup_fire_s, upd_fire_s;
    logic                 uq_pop_s, uq_full_s, uq_empty_s;
    uq_entry_t            uq_wdata_s, uq_head_s;
    logic [PHT_IDX_W-1:0] lookup_idx_s, upd_idx_s, pht_idx_s;
    logic                 pht_en_s, pht_we_s;
    logic [1:0]           pht_wdata_s;
    logic                 unused_s;

    function automatic logic [PHT_IDX_W-1:0] ghr_ext(input logic [GHR_SIZE-1:0] g);
        logic [PHT_IDX_W-1:0] r;
        r               = {PHT_IDX_W{1'b0}};
        r[GHR_SIZE-1:0] = g;
        return r;
    endfunction

    bp_update_fifo #(
        .W     ($bits(uq_entry_t)),
        .DEPTH (UQ_DEPTH)
    ) u_uq (
        .clk     (clk),
        .rst     (rst),
        .push    (upd_fire_s),
        .wr_data (uq_wdata_s),
        .pop     (uq_pop_s),
        .rd_data (uq_head_s),
        .full    (uq_full_s),
        .empty   (uq_empty_s)
    );

    assign unused_s = ^{lookup_pc[31:PHT_IDX_W+2], lookup_pc[1:0],
                        upd_pc[31:PHT_IDX_W+2], upd_pc[1:0], pht_rdata[0]};

    // Handshakes and index formation; pred_valid_q doubles as "lookup accepted last cycle".
    always_comb begin
        lookup_ready_s    = !rst && (state_q == IDLE) && !pred_valid_q && !uq_full_s;
        upd_ready_s       = !rst && (state_q != INIT) && !uq_full_s;
        lookup_fire_s     = lookup_valid && lookup_ready_s;
        upd_fire_s        = upd_valid && upd_ready_s;
        lookup_idx_s      = lookup_pc[PHT_IDX_W+1:2] ^ ghr_ext(ghr_q);
        upd_idx_s         = uq_head_s.pc_idx ^ ghr_ext(uq_head_s.ghr);
        uq_wdata_s.pc_idx = upd_pc[PHT_IDX_W+1:2];
        uq_wdata_s.ghr    = upd_ghr;
        uq_wdata_s.taken  = upd_taken;
    end

    // Port arbitration and controller next state.
    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        uq_pop_s    = 1'b0;
        pht_en_s    = 1'b0;
        pht_we_s    = 1'b0;
        pht_idx_s   = {PHT_IDX_W{1'b0}};
        pht_wdata_s = 2'b00;
        case (state_q)
            INIT: begin
                pht_en_s    = 1'b1;
                pht_we_s    = 1'b1;
                pht_idx_s   = init_idx_q;
                pht_wdata_s = CTR_WNT;
                init_idx_d  = init_idx_q + {{(PHT_IDX_W-1){1'b0}}, 1'b1};
                if (init_idx_q == IDX_LAST) begin
                    state_d = IDLE;
                end else begin
                    state_d = INIT;
                end
            end
            WR: begin
                pht_en_s    = 1'b1;
                pht_we_s    = 1'b1;
                pht_idx_s   = upd_idx_s;
                pht_wdata_s = ctr_update(pht_rdata, uq_head_s.taken);
                uq_pop_s    = 1'b1;
                state_d     = IDLE;
            end
            IDLE: begin
                if (lookup_fire_s) begin
                    pht_en_s  = 1'b1;
                    pht_idx_s = lookup_idx_s;
                end else if (!uq_empty_s) begin
                    pht_en_s  = 1'b1;
                    pht_idx_s = upd_idx_s;
                    state_d   = WR;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = INIT;
                init_idx_d = {PHT_IDX_W{1'b0}};
            end
        endcase
    end

    // Speculative history: mispredict recovery overrides the prediction shift.
    always_comb begin
        pred_valid_d = lookup_fire_s;
        if (lookup_fire_s) begin
            pred_ghr_d = ghr_q;
        end else begin
            pred_ghr_d = pred_ghr_q;
        end
        if (upd_fire_s && upd_mispredict) begin
            ghr_d = {upd_ghr[GHR_SIZE-2:0], upd_taken};
        end else if (pred_valid_q) begin
            ghr_d = {ghr_q[GHR_SIZE-2:0], pht_rdata[1]};
        end else begin
            ghr_d = ghr_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INIT;
            init_idx_q   <= {PHT_IDX_W{1'b0}};
            ghr_q        <= {GHR_SIZE{1'b0}};
            pred_valid_q <= 1'b0;
            pred_ghr_q   <= {GHR_SIZE{1'b0}};
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_ghr_q   <= pred_ghr_d;
        end
    end

    // A write in flight when rst rises is dropped rather than completed.
    assign pht_en       = pht_en_s && !rst;
    assign pht_we       = pht_we_s && !rst;
    assign pht_idx      = pht_idx_s;
    assign pht_wdata    = pht_wdata_s;
    assign lookup_ready = lookup_ready_s;
    assign upd_ready    = upd_ready_s;
    assign pred_valid   = pred_valid_q;
    assign pred_taken   = pred_valid_q && pht_rdata[1];
    assign pred_ghr     = pred_ghr_q;

endmodule
